// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared constants, FSM encoding and row priority helper for the keypad scanner
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

   localparam int KEY_ROWS = 4;
   localparam int KEY_COLS = 4;
   localparam int DIGITS   = 8;

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;

   // Lowest-numbered low row wins when several keys share a column
   function automatic logic [1:0] lowest_low(input logic [KEY_ROWS-1:0] rows_n);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = KEY_ROWS - 1; i >= 0; i--) begin
         if (!rows_n[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick_gen
// Purpose  : Free-running divider, one-cycle tick every SCAN_DIV clocks
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
   parameter int SCAN_DIV = 150000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int              c_div_w = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);

   logic [c_div_w-1:0] r_div;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (r_div == c_div_last) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + c_div_w'(1);
      end
   end

   assign tick = (r_div == c_div_last);

endmodule
`default_nettype wire

// File: rtl/keypad_hex_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_hex_entry
// Purpose  : 4x4 hex keypad scanner with debounce, key events and 32-bit entry register
// Revision : 1.0 - initial release
// ============================================================================
module keypad_hex_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 150000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row_n,
   output logic [3:0]  col_n,
   input  logic        clear,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [31:0] value,
   output logic [3:0]  digit_count
);

   localparam int                 c_cnt_w    = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_TICKS - 1);
   localparam logic [3:0]         c_max_dig  = 4'(DIGITS);

   logic [3:0]         r_sync1;
   logic [3:0]         r_rs_n;
   logic [1:0]         r_state;
   logic [1:0]         r_col;
   logic [1:0]         r_row;
   logic [c_cnt_w-1:0] r_cnt;

   logic w_tick;
   logic w_any_low;
   logic w_row_low;
   logic w_accept;

   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 4'b1111;
         r_rs_n  <= 4'b1111;
      end else begin
         r_sync1 <= row_n;
         r_rs_n  <= r_sync1;
      end
   end

   assign w_any_low = ~&r_rs_n;
   assign w_row_low = ~r_rs_n[r_row];
   assign w_accept  = w_tick && (r_state == DEBOUNCE) && w_row_low && (r_cnt == c_cnt_last);
   assign col_n     = ~(4'b0001 << r_col);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SCAN;
         r_col     <= 2'd0;
         r_row     <= 2'd0;
         r_cnt     <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (w_tick) begin
            case (r_state)
               SCAN: begin
                  if (w_any_low) begin
                     r_row   <= lowest_low(r_rs_n);
                     r_cnt   <= c_cnt_w'(1);
                     r_state <= DEBOUNCE;
                  end else begin
                     r_col <= r_col + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (w_accept) begin
                     key_code  <= {r_row, r_col};
                     key_valid <= 1'b1;
                     r_state   <= HELD;
                     r_cnt     <= '0;
                  end else if (w_row_low) begin
                     r_cnt <= r_cnt + c_cnt_w'(1);
                  end else begin
                     r_state <= SCAN;
                     r_col   <= r_col + 2'd1;
                     r_cnt   <= '0;
                  end
               end
               HELD: begin
                  // Only the latched key matters here; a bounce back low restarts release counting
                  if (w_row_low) begin
                     r_cnt <= '0;
                  end else if (r_cnt == c_cnt_last) begin
                     r_state <= SCAN;
                     r_col   <= r_col + 2'd1;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_w'(1);
                  end
               end
               default: begin
                  r_state <= SCAN;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value       <= 32'h0;
         digit_count <= 4'd0;
      end else if (clear) begin
         value       <= 32'h0;
         digit_count <= 4'd0;
      end else if (w_accept) begin
         value <= {value[27:0], r_row, r_col};
         if (digit_count != c_max_dig) digit_count <= digit_count + 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_hex_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_hex_entry
// Purpose  : Directed and randomized keypad stimulus against a sample-counting reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_hex_entry;

   localparam int SCAN_DIV = 4;
   localparam int DT       = 3;
   localparam int M_IDLE   = 0;
   localparam int M_CONF   = 1;
   localparam int M_HOLD   = 2;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        clear;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [31:0] value;
   logic [3:0]  digit_count;

   logic [15:0] keys;

   int vectors;
   int miscompares;
   int n;
   int dut_pulses;

   // Reference model: column under scan, sample run length, last accepted key
   int          m_col;
   int          m_mode;
   int          m_row;
   int          m_run;
   logic [3:0]  m_code;
   logic        m_valid;
   logic [31:0] m_value;
   int          m_cnt;

   keypad_hex_entry #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_TICKS (DT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_n       (row_n),
      .col_n       (col_n),
      .clear       (clear),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .value       (value),
      .digit_count (digit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its row to the driven-low column
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      n       = 0;
      m_col   = 0;
      m_mode  = M_IDLE;
      m_row   = 0;
      m_run   = 0;
      m_code  = 4'h0;
      m_valid = 1'b0;
      m_value = 32'h0;
      m_cnt   = 0;
   endtask

   task automatic model_tick();
      logic [3:0] low;
      for (int r = 0; r < 4; r++) low[r] = keys[r*4+m_col];
      case (m_mode)
         M_IDLE: begin
            if (low != 4'h0) begin
               m_row = 3;
               for (int r = 3; r >= 0; r--) if (low[r]) m_row = r;
               m_run  = 1;
               m_mode = M_CONF;
            end else begin
               m_col = (m_col + 1) % 4;
            end
         end
         M_CONF: begin
            if (low[m_row]) begin
               m_run++;
               if (m_run == DT) begin
                  m_valid = 1'b1;
                  m_code  = 4'(m_row*4 + m_col);
                  m_mode  = M_HOLD;
                  m_run   = 0;
               end
            end else begin
               m_mode = M_IDLE;
               m_col  = (m_col + 1) % 4;
            end
         end
         default: begin
            if (!low[m_row]) begin
               m_run++;
               if (m_run == DT) begin
                  m_mode = M_IDLE;
                  m_run  = 0;
                  m_col  = (m_col + 1) % 4;
               end
            end else begin
               m_run = 0;
            end
         end
      endcase
   endtask

   function automatic bit pending();
      return (m_mode == M_CONF) && keys[m_row*4+m_col] && (m_run == DT - 1);
   endfunction

   task automatic step();
      logic [3:0] ecol;
      @(posedge clk);
      n++;
      m_valid = 1'b0;
      if (n % SCAN_DIV == 0) model_tick();
      if (clear) begin
         m_value = 32'h0;
         m_cnt   = 0;
      end else if (m_valid) begin
         m_value = {m_value[27:0], m_code};
         if (m_cnt < 8) m_cnt++;
      end
      @(negedge clk);
      ecol = ~(4'b0001 << m_col);
      if (key_valid) dut_pulses++;
      check("col_n", 32'(col_n), 32'(ecol));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_code", 32'(key_code), 32'(m_code));
      check("value", value, m_value);
      check("digit_count", 32'(digit_count), 32'(m_cnt));
   endtask

   task automatic run_ticks(input int k);
      for (int i = 0; i < k; i++) begin
         do step(); while (n % SCAN_DIV != 0);
      end
   endtask

   task automatic wait_event(input int bound);
      bit got;
      got = 1'b0;
      for (int i = 0; i < bound && !got; i++) begin
         run_ticks(1);
         got = m_valid;
      end
      if (!got) check("event_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound && m_mode != M_IDLE; i++) run_ticks(1);
      if (m_mode != M_IDLE) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic press_release(input int code);
      keys[code] = 1'b1;
      wait_event(24);
      run_ticks(2);
      keys[code] = 1'b0;
      wait_idle(12);
   endtask

   initial begin
      logic [3:0] seq [9];
      bit         done;
      vectors     = 0;
      miscompares = 0;
      dut_pulses  = 0;
      keys        = 16'h0;
      clear       = 1'b0;
      rst_n       = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_col_n", 32'(col_n), 32'h0000000E);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_value", value, 32'h0);
      check("rst_digit_count", 32'(digit_count), 32'd0);
      rst_n = 1'b1;

      // Idle scan: one full column rotation
      run_ticks(4);
      check("idle_col_wrap", 32'(col_n), 32'h0000000E);
      check("idle_no_pulse", 32'(dut_pulses), 32'd0);

      // Long press of key 9 yields exactly one event
      dut_pulses = 0;
      keys[9] = 1'b1;
      run_ticks(10);
      keys[9] = 1'b0;
      wait_idle(12);
      check("k9_pulses", 32'(dut_pulses), 32'd1);
      check("k9_code", 32'(key_code), 32'h9);
      check("k9_value", value, 32'h9);
      check("k9_count", 32'(digit_count), 32'd1);

      // Two-sample glitch on key 7 while column 3 is active
      for (int i = 0; i < 8 && m_col != 3; i++) run_ticks(1);
      dut_pulses = 0;
      keys[7] = 1'b1;
      run_ticks(2);
      keys[7] = 1'b0;
      run_ticks(1);
      check("glitch_pulses", 32'(dut_pulses), 32'd0);
      check("glitch_col", 32'(col_n), 32'h0000000E);
      check("glitch_count", 32'(digit_count), 32'd1);

      // Nine digits overflow the eight-digit register
      seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
      foreach (seq[i]) press_release(int'(seq[i]));
      check("seq_value", value, 32'h2345678A);
      check("seq_count", 32'(digit_count), 32'd8);

      // Clear coincident with the key F event
      keys[15] = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         step();
         if (n % SCAN_DIV == SCAN_DIV - 1 && pending()) begin
            clear = 1'b1;
            step();
            clear = 1'b0;
            done  = 1'b1;
         end
      end
      if (!done) check("clear_timeout", 32'd0, 32'd1);
      check("clr_valid", 32'(key_valid), 32'd1);
      check("clr_code", 32'(key_code), 32'hF);
      check("clr_value", value, 32'h0);
      check("clr_count", 32'(digit_count), 32'd0);
      run_ticks(1);
      keys[15] = 1'b0;
      wait_idle(12);

      // Second key pressed during HELD is only seen after the first is released
      dut_pulses = 0;
      keys[0] = 1'b1;
      wait_event(24);
      keys[5] = 1'b1;
      run_ticks(3);
      keys[0] = 1'b0;
      wait_event(24);
      check("ovl_code", 32'(key_code), 32'h5);
      run_ticks(1);
      keys[5] = 1'b0;
      wait_idle(12);
      check("ovl_pulses", 32'(dut_pulses), 32'd2);
      check("ovl_value", value, 32'h5);
      check("ovl_count", 32'(digit_count), 32'd2);

      // Asynchronous reset in the middle of a debounce
      keys[3] = 1'b1;
      for (int i = 0; i < 12 && m_mode != M_CONF; i++) run_ticks(1);
      check("pre_rst_mode", 32'(m_mode), 32'(M_CONF));
      rst_n = 1'b0;
      #1;
      check("arst_col_n", 32'(col_n), 32'h0000000E);
      check("arst_valid", 32'(key_valid), 32'd0);
      check("arst_code", 32'(key_code), 32'h0);
      check("arst_value", value, 32'h0);
      check("arst_count", 32'(digit_count), 32'd0);
      keys = 16'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Randomized key activity with sporadic clears
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 9) < 4) keys[$urandom_range(0, 15)] ^= 1'b1;
         if ($countones(keys) > 2) keys = 16'h0;
         for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
            clear = ($urandom_range(0, 31) == 0);
            step();
         end
         clear = 1'b0;
         run_ticks(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
